// File: rtl/trainer_sweep_ctrl.sv
// Sweeps a 2-input gate datapath over SEL_FIRST..SEL_LAST and reports each gate's truth-table
// nibble over valid/ready. Optional golden-table self-check: define TRAINER_SELFCHECK_EN.
module trainer_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 2,
    parameter int SEL_FIRST     = 0,
    parameter int SEL_LAST      = 6
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic       i_gate_y,
    output logic       o_gate_a,
    output logic       o_gate_b,
    output logic [2:0] o_gate_sel,
    output logic       o_busy,
    output logic       o_tt_valid,
    input  logic       i_tt_ready,
    output logic [2:0] o_tt_sel,
    output logic [3:0] o_tt_nibble,
`ifdef TRAINER_SELFCHECK_EN
    output logic       o_tt_mismatch,
    output logic       o_fail_sticky,
`endif
    output logic       o_done
);

    localparam logic [2:0] LP_SEL_FIRST   = 3'(SEL_FIRST);
    localparam logic [2:0] LP_SEL_LAST    = 3'(SEL_LAST);
    localparam logic [3:0] LP_SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_REPORT,
        S_DONE
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_settle;
    logic [1:0] r_ab;
    logic [2:0] r_gate_sel;
    logic [2:0] r_tt_sel;
    logic [3:0] r_nibble;
    logic       w_launch;
    logic       w_sample;
    logic       w_handshake;
    logic       w_advance;

    assign w_handshake = (r_state == S_REPORT) && i_tt_ready && !i_abort;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Abort overrides every transition and suppresses all datapath strobes.
    always_comb begin
        w_next_state = r_state;
        w_launch     = 1'b0;
        w_sample     = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next_state = S_DRIVE;
                    w_launch     = 1'b1;
                end
            end
            S_DRIVE: begin
                if (r_settle == LP_SETTLE_LAST) begin
                    w_next_state = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                w_sample     = 1'b1;
                w_next_state = (r_ab == 2'b11) ? S_REPORT : S_DRIVE;
            end
            S_REPORT: begin
                if (w_handshake) begin
                    if (r_gate_sel == LP_SEL_LAST) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = S_DRIVE;
                        w_advance    = 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
        if (i_abort) begin
            w_next_state = S_IDLE;
            w_launch     = 1'b0;
            w_sample     = 1'b0;
            w_advance    = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_settle   <= '0;
            r_ab       <= '0;
            r_gate_sel <= '0;
            r_tt_sel   <= '0;
            r_nibble   <= '0;
        end else begin
            if (w_launch) begin
                r_settle <= '0;
            end else if (r_state == S_DRIVE) begin
                r_settle <= (r_settle == LP_SETTLE_LAST) ? 4'd0 : r_settle + 4'd1;
            end

            if (w_launch) begin
                r_gate_sel <= LP_SEL_FIRST;
                r_ab       <= 2'b00;
                r_nibble   <= 4'b0000;
            end else if (w_advance) begin
                r_gate_sel <= r_gate_sel + 3'd1;
                r_ab       <= 2'b00;
            end else if (w_sample) begin
                r_nibble[r_ab] <= i_gate_y;
                if (r_ab == 2'b11) begin
                    r_tt_sel <= r_gate_sel;
                end else begin
                    r_ab <= r_ab + 2'd1;
                end
            end
        end
    end

    assign o_gate_a    = r_ab[0];
    assign o_gate_b    = r_ab[1];
    assign o_gate_sel  = r_gate_sel;
    assign o_busy      = (r_state == S_DRIVE) || (r_state == S_SAMPLE) || (r_state == S_REPORT);
    assign o_tt_valid  = (r_state == S_REPORT);
    assign o_tt_sel    = r_tt_sel;
    assign o_tt_nibble = r_nibble;
    assign o_done      = (r_state == S_DONE);

`ifdef TRAINER_SELFCHECK_EN
    logic w_mismatch;
    logic r_fail_sticky;

    function automatic logic [3:0] golden_nibble(input logic [2:0] sel);
        logic [3:0] nib;
        case (sel)
            3'd0:    nib = 4'h8;
            3'd1:    nib = 4'hE;
            3'd2:    nib = 4'h5;
            3'd3:    nib = 4'h7;
            3'd4:    nib = 4'h1;
            3'd5:    nib = 4'h6;
            3'd6:    nib = 4'h9;
            default: nib = 4'h0;
        endcase
        return nib;
    endfunction

    assign w_mismatch = (r_state == S_REPORT) && (r_nibble != golden_nibble(r_tt_sel));

    // Sticky failure survives to the end of the sweep; only a new sweep clears it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fail_sticky <= 1'b0;
        end else if (w_launch) begin
            r_fail_sticky <= 1'b0;
        end else if (w_handshake && w_mismatch) begin
            r_fail_sticky <= 1'b1;
        end
    end

    assign o_tt_mismatch = w_mismatch;
    assign o_fail_sticky = r_fail_sticky;
`endif

endmodule

// File: tb/tb_trainer_sweep_ctrl.sv
// Bench for trainer_sweep_ctrl: table vectors, scoreboarded sweeps against a table-driven
// gate datapath model, and multi-cycle abort / reset / stall corner cases.
module tb_trainer_sweep_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       ready;

    logic       aA, bA, busyA, validA, doneA, yA;
    logic [2:0] selA, ttSelA;
    logic [3:0] nibA;
    logic       aB, bB, busyB, validB, doneB, yB;
    logic [2:0] selB, ttSelB;
    logic [3:0] nibB;
`ifdef TRAINER_SELFCHECK_EN
    logic       mismatchA, failA, mismatchB, failB;
    logic       obsMismatch, obsFail;
`endif

    logic [3:0] dpTable [8];
    bit         useB;
    int         total;
    int         bad;

    logic       obsA, obsB, obsBusy, obsValid, obsDone;
    logic [2:0] obsGateSel, obsTtSel;
    logic [3:0] obsNib;

    typedef struct {
        bit start;
        bit abort;
        bit expBusy;
        bit expValid;
        bit expDone;
        bit expA;
        bit expB;
        int expSel;
    } vec_t;

    vec_t vecs [9];

    assign yA = dpTable[selA][{bA, aA}];
    assign yB = dpTable[selB][{bB, aB}];

    assign obsA       = useB ? aB : aA;
    assign obsB       = useB ? bB : bA;
    assign obsBusy    = useB ? busyB : busyA;
    assign obsValid   = useB ? validB : validA;
    assign obsDone    = useB ? doneB : doneA;
    assign obsGateSel = useB ? selB : selA;
    assign obsTtSel   = useB ? ttSelB : ttSelA;
    assign obsNib     = useB ? nibB : nibA;
`ifdef TRAINER_SELFCHECK_EN
    assign obsMismatch = useB ? mismatchB : mismatchA;
    assign obsFail     = useB ? failB : failA;
`endif

    trainer_sweep_ctrl #(.SETTLE_CYCLES(2), .SEL_FIRST(0), .SEL_LAST(6)) u_dutA (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort), .i_gate_y(yA),
        .o_gate_a(aA), .o_gate_b(bA), .o_gate_sel(selA), .o_busy(busyA),
        .o_tt_valid(validA), .i_tt_ready(ready), .o_tt_sel(ttSelA), .o_tt_nibble(nibA),
`ifdef TRAINER_SELFCHECK_EN
        .o_tt_mismatch(mismatchA), .o_fail_sticky(failA),
`endif
        .o_done(doneA)
    );

    trainer_sweep_ctrl #(.SETTLE_CYCLES(1), .SEL_FIRST(5), .SEL_LAST(5)) u_dutB (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort), .i_gate_y(yB),
        .o_gate_a(aB), .o_gate_b(bB), .o_gate_sel(selB), .o_busy(busyB),
        .o_tt_valid(validB), .i_tt_ready(ready), .o_tt_sel(ttSelB), .o_tt_nibble(nibB),
`ifdef TRAINER_SELFCHECK_EN
        .o_tt_mismatch(mismatchB), .o_fail_sticky(failB),
`endif
        .o_done(doneB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] goldenOf(input logic [2:0] s);
        logic [3:0] n;
        case (s)
            3'd0:    n = 4'h8;
            3'd1:    n = 4'hE;
            3'd2:    n = 4'h5;
            3'd3:    n = 4'h7;
            3'd4:    n = 4'h1;
            3'd5:    n = 4'h6;
            3'd6:    n = 4'h9;
            default: n = 4'h0;
        endcase
        return n;
    endfunction

    function automatic int curFirst();
        return useB ? 5 : 0;
    endfunction

    function automatic int curLast();
        return useB ? 5 : 6;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_a"}, obsA, 0);
        checkOutput({tag, "_b"}, obsB, 0);
        checkOutput({tag, "_gate_sel"}, obsGateSel, 0);
        checkOutput({tag, "_busy"}, obsBusy, 0);
        checkOutput({tag, "_valid"}, obsValid, 0);
        checkOutput({tag, "_tt_sel"}, obsTtSel, 0);
        checkOutput({tag, "_nibble"}, obsNib, 0);
        checkOutput({tag, "_done"}, obsDone, 0);
`ifdef TRAINER_SELFCHECK_EN
        checkOutput({tag, "_mismatch"}, obsMismatch, 0);
        checkOutput({tag, "_fail_sticky"}, obsFail, 0);
`endif
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        start = v.start;
        abort = v.abort;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checkOutput($sformatf("vec%0d_busy", idx), obsBusy, v.expBusy);
        checkOutput($sformatf("vec%0d_valid", idx), obsValid, v.expValid);
        checkOutput($sformatf("vec%0d_done", idx), obsDone, v.expDone);
        checkOutput($sformatf("vec%0d_a", idx), obsA, v.expA);
        checkOutput($sformatf("vec%0d_b", idx), obsB, v.expB);
        checkOutput($sformatf("vec%0d_sel", idx), obsGateSel, v.expSel);
    endtask

    // One full sweep scoreboarded against dpTable: expected gates are curFirst..curLast in order.
    task automatic runSweep(input int readyPct, input int stallSel, input int stallLen,
                            input int expFirst, input int expDone);
        int c, firstValid, doneAt, hs, stalled, nGates, expSel;
        bit holding, expFail, mmExp;
        logic [2:0] holdTtSel, holdGateSel;
        logic [3:0] holdNib;
        logic [1:0] holdAb;
        nGates = curLast() - curFirst() + 1;
        firstValid = -1;
        doneAt = -1;
        hs = 0;
        stalled = 0;
        holding = 1'b0;
        expFail = 1'b0;
        holdTtSel = '0;
        holdGateSel = '0;
        holdNib = '0;
        holdAb = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("launch_sel", obsGateSel, curFirst());
        checkOutput("launch_ab", {obsB, obsA}, 0);
        c = 0;
        while (doneAt < 0 && c < 1000) begin
            if (obsValid && firstValid < 0) firstValid = c + 1;
            if (obsDone) begin
                doneAt = c + 1;
                checkOutput("busy_at_done", obsBusy, 0);
            end
`ifdef TRAINER_SELFCHECK_EN
            checkOutput("fail_sticky", obsFail, expFail);
`endif
            if (obsValid && holding) begin
                checkOutput("stall_tt_sel", obsTtSel, holdTtSel);
                checkOutput("stall_nibble", obsNib, holdNib);
                checkOutput("stall_gate_sel", obsGateSel, holdGateSel);
                checkOutput("stall_gate_ab", {obsB, obsA}, holdAb);
            end
            if (obsValid && int'(obsTtSel) == stallSel && stalled < stallLen) begin
                ready = 1'b0;
                stalled++;
            end else begin
                ready = ($urandom_range(0, 99) < readyPct);
            end
            if (obsValid && ready) begin
                expSel = (curFirst() + hs) % 8;
                checkOutput("hs_tt_sel", obsTtSel, expSel);
                checkOutput("hs_nibble", obsNib, dpTable[expSel]);
`ifdef TRAINER_SELFCHECK_EN
                mmExp = (dpTable[expSel] != goldenOf(3'(expSel)));
                checkOutput("hs_mismatch", obsMismatch, mmExp);
                expFail = expFail | mmExp;
`endif
                hs++;
                holding = 1'b0;
            end else if (obsValid && !holding) begin
                holding = 1'b1;
                holdTtSel = obsTtSel;
                holdNib = obsNib;
                holdGateSel = obsGateSel;
                holdAb = {obsB, obsA};
            end
            tick();
            c++;
        end
        checkOutput("done_seen", doneAt >= 0, 1);
        checkOutput("handshake_count", hs, nGates);
        if (expFirst >= 0) checkOutput("first_valid_cycle", firstValid, expFirst);
        if (expDone >= 0) checkOutput("done_cycle", doneAt, expDone);
        checkOutput("done_one_cycle", obsDone, 0);
        checkOutput("idle_after_done", obsBusy, 0);
`ifdef TRAINER_SELFCHECK_EN
        checkOutput("fail_sticky_end", obsFail, expFail);
`endif
        ready = 1'b0;
    endtask

    initial begin
        int w;
        total = 0;
        bad = 0;
        useB = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        ready = 1'b0;
        rst_n = 1'b0;
        for (int g = 0; g < 8; g++) dpTable[g] = goldenOf(3'(g));

        vecs[0] = '{0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1] = '{1, 1, 0, 0, 0, 0, 0, 0};
        vecs[2] = '{0, 1, 0, 0, 0, 0, 0, 0};
        vecs[3] = '{1, 0, 1, 0, 0, 0, 0, 0};
        vecs[4] = '{1, 0, 1, 0, 0, 0, 0, 0};
        vecs[5] = '{0, 0, 1, 0, 0, 0, 0, 0};
        vecs[6] = '{0, 0, 1, 0, 0, 1, 0, 0};
        vecs[7] = '{0, 1, 0, 0, 0, 1, 0, 0};
        vecs[8] = '{0, 0, 0, 0, 0, 1, 0, 0};

        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) applyStimulus(vecs[i], i);

        runSweep(100, -1, 0, 13, 92);
        runSweep(100, 2, 5, 13, 97);

        for (int r = 0; r < 3; r++) begin
            for (int g = 0; g < 8; g++) dpTable[g] = 4'($urandom_range(0, 15));
            runSweep(60, -1, 0, -1, -1);
        end
        for (int g = 0; g < 8; g++) dpTable[g] = goldenOf(3'(g));

        // Abort in the first DRIVE cycle of gate 3, then a clean restart.
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        w = 0;
        while (!(obsGateSel == 3'd3 && obsBusy && !obsValid) && w < 300) begin
            tick();
            w++;
        end
        checkOutput("abort_reach_sel3", w < 300, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_busy", obsBusy, 0);
        checkOutput("abort_valid", obsValid, 0);
        checkOutput("abort_done", obsDone, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("abort_no_done", obsDone, 0);
        end
        ready = 1'b0;
        runSweep(100, -1, 0, 13, 92);

        start = 1'b1;
        tick();
        start = 1'b0;
        ready = 1'b1;
        repeat (20) tick();
        checkOutput("pre_reset_busy", obsBusy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("async_reset");
        tick();
        rst_n = 1'b1;
        ready = 1'b0;
        tick();
        runSweep(100, -1, 0, 13, 92);

        useB = 1'b1;
        runSweep(100, -1, 0, 9, 10);
        useB = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();

`ifdef TRAINER_SELFCHECK_EN
        dpTable[1] = 4'h0;
        runSweep(100, -1, 0, 13, 92);
        dpTable[1] = goldenOf(3'd1);
        runSweep(100, -1, 0, 13, 92);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
